instr_encoder: RTL and testbench

Encoder and loader for the 9-bit instruction format consumed by the control decoder. It accepts one symbolic instruction per valid/ready handshake, checks its fields, and packs it into a 9-bit word. Each legal word is written to the instruction memory write port at consecutive addresses. It sits between the test/boot program source and instruction memory, and produces exactly the opcode/mode encodings the decoder interprets.

---
 rtl/instr_encoder.sv | 129 ++++++++++++
 tb/tb_instr_encoder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_encoder.sv
// instr_encoder: checks and packs symbolic instructions into 9-bit words.
// Each legal word goes to consecutive instruction memory addresses.
module instr_encoder #(
    parameter int DEPTH = 256,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_op,
    input  logic [2:0]    in_ra,
    input  logic [2:0]    in_rb,
    input  logic [3:0]    in_imm,
    input  logic [2:0]    in_mode,
    input  logic          in_last,
    output logic          imem_we,
    output logic [AW-1:0] imem_addr,
    output logic [8:0]    imem_wdata,
    output logic [AW:0]   count,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic [1:0]    err_code
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE, S_ERR} state_t;

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    state_t        state_q, state_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [8:0]    wdata_q, wdata_d;
    logic [AW:0]   count_q, count_d;
    logic [1:0]    err_code_q, err_code_d;

    logic [8:0]    word_c;
    logic [1:0]    code_c;
    logic          accept;

    // Readiness depends only on registered state and count, never on in_valid.
    assign in_ready = (state_q == S_RUN) && (count_q < DEPTH_C);
    // start owns the cycle it is asserted in; no accept is taken alongside it.
    assign accept   = in_valid && in_ready && !start;

    // Field encoding and legality check; code_c == 0 means the word is legal.
    always_comb begin
        word_c = '0;
        code_c = 2'b00;
        case (in_op)
            4'd0, 4'd1, 4'd2: word_c = {in_op[2:0], in_ra, in_rb};
            4'd3, 4'd4: begin
                word_c = {3'b011, in_op[2], in_ra[1:0], in_rb};
                if (in_ra[2]) code_c = 2'b10;
            end
            4'd5: begin
                word_c = {3'b100, in_ra[1:0], in_imm};
                if (!in_ra[2]) code_c = 2'b10;
            end
            4'd6: begin
                word_c = {3'b101, in_mode, in_ra};
                case (in_mode)
                    3'b000, 3'b010, 3'b011, 3'b100, 3'b110: code_c = 2'b00;
                    default: code_c = 2'b11;
                endcase
            end
            4'd7:    word_c = {3'b110, in_ra, in_mode};
            default: code_c = 2'b01;
        endcase
    end

    // Next-state: start restarts the session; an accept either writes or aborts.
    always_comb begin
        state_d    = state_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        count_d    = count_q;
        err_code_d = err_code_q;
        if (start) begin
            state_d    = S_RUN;
            addr_d     = '0;
            count_d    = '0;
            err_code_d = 2'b00;
        end else if (accept) begin
            if (code_c != 2'b00) begin
                state_d    = S_ERR;
                err_code_d = code_c;
            end else begin
                we_d    = 1'b1;
                addr_d  = count_q[AW-1:0];
                wdata_d = word_c;
                count_d = count_q + 1'b1;
                if (in_last || (count_q == DEPTH_C - 1'b1)) state_d = S_DONE;
            end
        end
    end

    // Session FSM and registered write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            count_q    <= '0;
            err_code_q <= 2'b00;
        end else begin
            state_q    <= state_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            count_q    <= count_d;
            err_code_q <= err_code_d;
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign count      = count_q;
    assign busy       = (state_q == S_RUN);
    assign done       = (state_q == S_DONE);
    assign err        = (state_q == S_ERR);
    assign err_code   = err_code_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: a DEPTH=256 instance for encodings and
// session control, and a DEPTH=4 instance sharing the inputs for the full boundary.
module tb_instr_encoder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0, in_valid = 1'b0, in_last = 1'b0;
    logic [3:0] in_op = '0, in_imm = '0;
    logic [2:0] in_ra = '0, in_rb = '0, in_mode = '0;

    logic       rdy, we, busy, done, err;
    logic [7:0] addr;
    logic [8:0] wdata;
    logic [8:0] cnt;
    logic [1:0] ecode;

    logic       rdy4, we4, busy4, done4, err4;
    logic [1:0] addr4;
    logic [8:0] wdata4;
    logic [2:0] cnt4;
    logic [1:0] ecode4;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    instr_encoder #(.DEPTH(256), .AW(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(rdy),
        .in_op(in_op), .in_ra(in_ra), .in_rb(in_rb), .in_imm(in_imm), .in_mode(in_mode),
        .in_last(in_last), .imem_we(we), .imem_addr(addr), .imem_wdata(wdata),
        .count(cnt), .busy(busy), .done(done), .err(err), .err_code(ecode)
    );

    instr_encoder #(.DEPTH(4), .AW(2)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(rdy4),
        .in_op(in_op), .in_ra(in_ra), .in_rb(in_rb), .in_imm(in_imm), .in_mode(in_mode),
        .in_last(in_last), .imem_we(we4), .imem_addr(addr4), .imem_wdata(wdata4),
        .count(cnt4), .busy(busy4), .done(done4), .err(err4), .err_code(ecode4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // One-cycle handshake; returns #1 into the cycle after the accept edge.
    task automatic issue(input logic [3:0] op, input logic [2:0] ra, input logic [2:0] rb,
                         input logic [3:0] imm, input logic [2:0] mode, input logic last);
        in_op = op; in_ra = ra; in_rb = rb; in_imm = imm; in_mode = mode; in_last = last;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic chk_write(input string tag, input logic [7:0] a, input logic [8:0] d);
        chk({tag, ".we"}, 32'(we), 1);
        chk({tag, ".addr"}, 32'(addr), 32'(a));
        chk({tag, ".wdata"}, 32'(wdata), 32'(d));
    endtask

    initial begin
        // reset state
        #12;
        chk("rst.ready", 32'(rdy), 0);
        chk("rst.we", 32'(we), 0);
        chk("rst.addr", 32'(addr), 0);
        chk("rst.wdata", 32'(wdata), 0);
        chk("rst.count", 32'(cnt), 0);
        chk("rst.flags", 32'({busy, done, err, ecode}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("idle.ready", 32'(rdy), 0);

        // session 1: ADD, XOR, ADI(last)
        pulse_start();
        chk("s1.ready", 32'(rdy), 1);
        chk("s1.busy", 32'(busy), 1);
        issue(4'd0, 3'd1, 3'd2, 4'd0, 3'd0, 1'b0);
        chk_write("add", 8'd0, 9'h00A);
        chk("add.count", 32'(cnt), 1);
        issue(4'd1, 3'd7, 3'd0, 4'd0, 3'd0, 1'b0);
        chk_write("xor", 8'd1, 9'h078);
        issue(4'd5, 3'd5, 3'd0, 4'hD, 3'd0, 1'b1);
        chk_write("adi", 8'd2, 9'h11D);
        chk("s1.count", 32'(cnt), 3);
        chk("s1.done", 32'({done, err, busy}), 32'b100);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("s1.hold_we", 32'(we), 0);
        chk("s1.hold_ready", 32'(rdy), 0);
        chk("s1.hold_count", 32'(cnt), 3);

        // session 2: LOD, STO, SHF, BR
        pulse_start();
        chk("s2.count_clr", 32'(cnt), 0);
        chk("s2.done_clr", 32'(done), 0);
        issue(4'd3, 3'd2, 3'd6, 4'd0, 3'd0, 1'b0);
        chk_write("lod", 8'd0, 9'h0D6);
        issue(4'd4, 3'd3, 3'd1, 4'd0, 3'd0, 1'b0);
        chk_write("sto", 8'd1, 9'h0F9);
        issue(4'd6, 3'd4, 3'd0, 4'd0, 3'b110, 1'b0);
        chk_write("shf", 8'd2, 9'h174);
        issue(4'd7, 3'd5, 3'd0, 4'd0, 3'b101, 1'b0);
        chk_write("br", 8'd3, 9'h1AD);
        chk("s2.count", 32'(cnt), 4);

        // error cases
        pulse_start();
        issue(4'd5, 3'd2, 3'd0, 4'd1, 3'd0, 1'b0);
        chk("e_reg.we", 32'(we), 0);
        chk("e_reg.flags", 32'({err, done, busy}), 32'b100);
        chk("e_reg.code", 32'(ecode), 2);
        chk("e_reg.ready", 32'(rdy), 0);
        issue(4'd0, 3'd1, 3'd1, 4'd0, 3'd0, 1'b0);
        chk("e_reg.no_write", 32'(we), 0);
        chk("e_reg.count", 32'(cnt), 0);
        pulse_start();
        issue(4'd6, 3'd1, 3'd0, 4'd0, 3'b001, 1'b0);
        chk("e_shf.we", 32'(we), 0);
        chk("e_shf.code", 32'(ecode), 3);
        pulse_start();
        chk("e.restart", 32'({err, busy, ecode}), 32'b0100);
        issue(4'd9, 3'd0, 3'd0, 4'd0, 3'd0, 1'b0);
        chk("e_op.we", 32'(we), 0);
        chk("e_op.code", 32'(ecode), 1);
        chk("e_op.err", 32'(err), 1);
        pulse_start();
        issue(4'd3, 3'd4, 3'd0, 4'd0, 3'd0, 1'b0);
        chk("e_lod.code", 32'(ecode), 2);

        // full boundary on the DEPTH=4 instance, in_valid held high
        pulse_start();
        in_op = 4'd0; in_ra = 3'd1; in_rb = 3'd2; in_last = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("full.we", 32'(we4), 1);
            chk("full.addr", 32'(addr4), 32'(i));
            chk("full.count", 32'(cnt4), 32'(i + 1));
        end
        chk("full.ready", 32'(rdy4), 0);
        chk("full.done", 32'({done4, err4}), 32'b10);
        tick();
        chk("full.no5th", 32'(we4), 0);
        chk("full.count_hold", 32'(cnt4), 4);
        in_valid = 1'b0;

        // start one cycle after an accept, back-to-back traffic
        pulse_start();
        in_valid = 1'b1;
        tick();
        chk_write("b2b0", 8'd0, 9'h00A);
        tick();
        start = 1'b1;
        chk_write("b2b1", 8'd1, 9'h00A);
        tick();
        start = 1'b0;
        chk("b2b.count_clr", 32'(cnt), 0);
        chk("b2b.we_gap", 32'(we), 0);
        tick();
        chk_write("b2b2", 8'd0, 9'h00A);
        chk("b2b.count", 32'(cnt), 1);

        // asynchronous reset mid-session with in_valid still high
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst.we", 32'(we), 0);
        chk("arst.count", 32'(cnt), 0);
        chk("arst.addr", 32'(addr), 0);
        chk("arst.wdata", 32'(wdata), 0);
        chk("arst.flags", 32'({rdy, busy, done, err, ecode}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("arst.post_we", 32'(we), 0);
            chk("arst.post_ready", 32'(rdy), 0);
        end
        in_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
